// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel gradient-magnitude stage.
// Kernels are indexed [row][col], row 0 being the oldest line in the window.
package sobel_pkg;

    localparam int PIX_W  = 8;
    localparam int MAG_W  = 12;
    localparam int GRAD_W = 11;

    typedef logic [PIX_W-1:0]         pixel_t;
    typedef logic signed [GRAD_W-1:0] grad_t;
    typedef logic [MAG_W-1:0]         mag_t;

    localparam pixel_t SAT_MAX = 8'd255;

    localparam grad_t KX [3][3] = '{
        '{-11'sd1, 11'sd0, 11'sd1},
        '{-11'sd2, 11'sd0, 11'sd2},
        '{-11'sd1, 11'sd0, 11'sd1}
    };

    localparam grad_t KY [3][3] = '{
        '{-11'sd1, -11'sd2, -11'sd1},
        '{ 11'sd0,  11'sd0,  11'sd0},
        '{ 11'sd1,  11'sd2,  11'sd1}
    };

endpackage

// File: rtl/line_buffer.sv
// One-line pixel delay: returns the pixel stored at addr one line ago and
// overwrites it with din on the same write strobe.
module line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = 320,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    pixel_t mem_q [DEPTH];

    // Read is combinational so the old column is available in the same cycle it is replaced.
    assign dout = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= din;
        end
    end

endmodule

// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel |Gx|+|Gy| stage with a two-cycle fixed latency.
// Output for pixel (r,c) is centred at (r-1,c-1), zeroed when r<2 or c<2.
module sobel_edge
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             sof,
    output logic [PIX_W-1:0] edge_out,
    output logic             edge_valid
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    function automatic logic [GRAD_W-1:0] abs_grad(input grad_t g);
        grad_t neg;
        neg = -g;
        return g[GRAD_W-1] ? neg : g;
    endfunction

    function automatic pixel_t sat_mag(input mag_t s);
        return (s > MAG_W'(SAT_MAX)) ? SAT_MAX : s[PIX_W-1:0];
    endfunction

    logic [ROW_W-1:0] row_q, row_d, cur_row;
    logic [COL_W-1:0] col_q, col_d, cur_col;
    logic [ROW_W-1:0] tag_row_q, tag_row_d;
    logic [COL_W-1:0] tag_col_q, tag_col_d;
    logic             s1_valid_q, s1_valid_d;
    pixel_t           win_q [3][3];
    pixel_t           win_d [3][3];
    pixel_t           lb0_rd, lb1_rd;
    grad_t            gx, gy;
    mag_t             mag_sum;
    logic             border;
    pixel_t           edge_out_q, edge_out_d;
    logic             edge_valid_q, edge_valid_d;

    // lb0 holds the previous line, lb1 the line before that.
    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
        .clk  (clk),
        .we   (pix_valid),
        .addr (cur_col),
        .din  (pix_in),
        .dout (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
        .clk  (clk),
        .we   (pix_valid),
        .addr (cur_col),
        .din  (lb0_rd),
        .dout (lb1_rd)
    );

    // Position of the incoming pixel; sof resyncs it to the frame origin.
    always_comb begin
        cur_row = (pix_valid && sof) ? '0 : row_q;
        cur_col = (pix_valid && sof) ? '0 : col_q;
        row_d   = row_q;
        col_d   = col_q;
        if (pix_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end
        end
    end

    // Stage 1: window shift and position tag
    always_comb begin
        win_d      = win_q;
        tag_row_d  = tag_row_q;
        tag_col_d  = tag_col_q;
        s1_valid_d = pix_valid;
        if (pix_valid) begin
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = pix_in;
            tag_row_d   = cur_row;
            tag_col_d   = cur_col;
        end
    end

    // Stage 2: gradient magnitude, border mask and saturation
    always_comb begin
        gx = '0;
        gy = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                gx = gx + KX[i][j] * $signed({{(GRAD_W-PIX_W){1'b0}}, win_q[i][j]});
                gy = gy + KY[i][j] * $signed({{(GRAD_W-PIX_W){1'b0}}, win_q[i][j]});
            end
        end
        mag_sum = MAG_W'(abs_grad(gx)) + MAG_W'(abs_grad(gy));
        border  = (tag_row_q < ROW_W'(2)) || (tag_col_q < COL_W'(2));

        edge_out_d   = edge_out_q;
        edge_valid_d = s1_valid_q;
        if (s1_valid_q) begin
            edge_out_d = border ? '0 : sat_mag(mag_sum);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q        <= '0;
            col_q        <= '0;
            tag_row_q    <= '0;
            tag_col_q    <= '0;
            s1_valid_q   <= 1'b0;
            edge_out_q   <= '0;
            edge_valid_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            tag_row_q    <= tag_row_d;
            tag_col_q    <= tag_col_d;
            s1_valid_q   <= s1_valid_d;
            edge_out_q   <= edge_out_d;
            edge_valid_q <= edge_valid_d;
            win_q        <= win_d;
        end
    end

    assign edge_out   = edge_out_q;
    assign edge_valid = edge_valid_q;

endmodule
